// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 single-wire transmitter: FSM encoding,
// 50 MHz default timing and the wire-order colour reorder.
package ws2812_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HIGH  = 2'd1;
    localparam logic [1:0] ST_LOW   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    localparam int DEF_T0H_CYC   = 20;
    localparam int DEF_T1H_CYC   = 40;
    localparam int DEF_BIT_CYC   = 63;
    localparam int DEF_RESET_CYC = 3000;

    // The LED expects green first, then red, then blue.
    function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// One WS2812 bit slot: counts 0..BIT_CYC-1 and drives the line high for the
// first T0H_CYC or T1H_CYC cycles depending on the bit value.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC = DEF_T0H_CYC,
    parameter int T1H_CYC = DEF_T1H_CYC,
    parameter int BIT_CYC = DEF_BIT_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_value,
    output logic dout_bit,
    output logic bit_end
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HIGH_0   = CW'(T0H_CYC);
    localparam logic [CW-1:0] HIGH_1   = CW'(T1H_CYC);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          active;
    logic          active_next;
    logic          bit_q;
    logic          bit_next;

    // A start in the final cycle of a slot begins the next slot with no gap.
    always_comb begin
        cnt_next    = cnt;
        active_next = active;
        bit_next    = bit_q;
        if (start) begin
            cnt_next    = '0;
            active_next = 1'b1;
            bit_next    = bit_value;
        end else if (active) begin
            if (cnt == CNT_LAST) begin
                cnt_next    = '0;
                active_next = 1'b0;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // The line is a flop so it can never glitch while the counter ripples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= '0;
            active   <= 1'b0;
            bit_q    <= 1'b0;
            dout_bit <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            active   <= active_next;
            bit_q    <= bit_next;
            dout_bit <= active_next && (cnt_next < (bit_next ? HIGH_1 : HIGH_0));
        end
    end

    assign bit_end = active && (cnt == CNT_LAST);

endmodule

// File: rtl/ws2812_serial_tx.sv
// WS2812 frame transmitter: accepts RGB pixels over valid/ready, shifts them out
// GRB MSB-first and closes the frame with the latch low-time.
module ws2812_serial_tx
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC   = DEF_T0H_CYC,
    parameter int T1H_CYC   = DEF_T1H_CYC,
    parameter int BIT_CYC   = DEF_BIT_CYC,
    parameter int RESET_CYC = DEF_RESET_CYC,
    parameter int NUM_LEDS  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] s_color,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dout,
    output logic        busy,
    output logic        frame_done
);

    localparam int TW = $clog2(RESET_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(RESET_CYC - 1);
    localparam logic [8:0]    LED_COUNT = 9'(NUM_LEDS);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [23:0]   shift;
    logic [23:0]   shift_next;
    logic [4:0]    bit_idx;
    logic [4:0]    bit_idx_next;
    logic [7:0]    pix_cnt;
    logic [7:0]    pix_next;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_next;
    logic          ready_en;

    logic [23:0]   grb;
    logic [8:0]    pix_inc;
    logic          last_pix;
    logic          more_pix;
    logic          in_bit;
    logic          pixel_end;
    logic          xfer;
    logic          start;
    logic          start_bit;
    logic          bit_end;
    logic          dout_bit;

    assign grb       = grb_reorder(s_color);
    assign pix_inc   = {1'b0, pix_cnt} + 9'd1;
    assign last_pix  = (pix_inc == LED_COUNT);
    assign more_pix  = (pix_inc < LED_COUNT);
    assign in_bit    = (state == ST_HIGH) || (state == ST_LOW);
    assign pixel_end = in_bit && bit_end && (bit_idx == 5'd0);

    // ready_en holds s_ready low until the first clock after reset release.
    assign s_ready    = ready_en && ((state == ST_IDLE) || (pixel_end && more_pix));
    assign xfer       = s_valid && s_ready;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (tmr == TMR_LAST) &&
                        ((state == ST_LATCH) || ((state == ST_IDLE) && (pix_cnt != 8'd0)));
    assign dout       = dout_bit;

    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_idx_next = bit_idx;
        pix_next     = pix_cnt;
        tmr_next     = tmr;
        start        = 1'b0;
        start_bit    = shift[22];

        case (state)
            ST_IDLE: begin
                // A partly sent frame latches by itself if the source starves.
                if (pix_cnt != 8'd0) begin
                    if (tmr == TMR_LAST) begin
                        tmr_next = '0;
                        pix_next = '0;
                    end else begin
                        tmr_next = tmr + 1'b1;
                    end
                end
                if (xfer) begin
                    state_next = ST_HIGH;
                    tmr_next   = '0;
                end
            end
            ST_HIGH, ST_LOW: begin
                if (bit_end) begin
                    if (bit_idx != 5'd0) begin
                        start        = 1'b1;
                        start_bit    = shift[22];
                        shift_next   = {shift[22:0], 1'b0};
                        bit_idx_next = bit_idx - 5'd1;
                        state_next   = ST_HIGH;
                    end else if (last_pix) begin
                        state_next = ST_LATCH;
                        tmr_next   = '0;
                    end else begin
                        pix_next   = pix_inc[7:0];
                        tmr_next   = '0;
                        state_next = xfer ? ST_HIGH : ST_IDLE;
                    end
                end else if ((state == ST_HIGH) && !dout_bit) begin
                    state_next = ST_LOW;
                end
            end
            ST_LATCH: begin
                if (tmr == TMR_LAST) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                    pix_next   = '0;
                end else begin
                    tmr_next = tmr + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (xfer) begin
            shift_next   = grb;
            bit_idx_next = 5'd23;
            start        = 1'b1;
            start_bit    = grb[23];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_idx  <= '0;
            pix_cnt  <= '0;
            tmr      <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            bit_idx  <= bit_idx_next;
            pix_cnt  <= pix_next;
            tmr      <= tmr_next;
            ready_en <= 1'b1;
        end
    end

    // Pixel data needs no reset: a pixel only starts after a fresh load.
    always_ff @(posedge clk) begin
        shift <= shift_next;
    end

    ws2812_bit_timer #(
        .T0H_CYC(T0H_CYC),
        .T1H_CYC(T1H_CYC),
        .BIT_CYC(BIT_CYC)
    ) u_bit_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bit_value(start_bit),
        .dout_bit (dout_bit),
        .bit_end  (bit_end)
    );

endmodule

// File: tb/tb_ws2812_serial_tx.sv
// Directed bench for ws2812_serial_tx: three instances (1, 3 and 2 LEDs per frame)
// with a line decoder per instance checking pixels against an expected-pixel queue.
module tb_ws2812_serial_tx;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int BITC = 63;
    localparam int RSTC = 3000;
    localparam int PIXC = 24 * BITC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  valid_w;
    logic [2:0]  ready_w;
    logic [2:0]  dout_w;
    logic [2:0]  busy_w;
    logic [2:0]  fd_w;
    logic [23:0] color_w [3];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int fd_cnt [3];
    logic [23:0] q0 [$];
    logic [23:0] q1 [$];
    logic [23:0] q2 [$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) for (int i = 0; i < 3; i++) if (fd_w[i]) fd_cnt[i] <= fd_cnt[i] + 1;

    ws2812_serial_tx #(.T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC), .NUM_LEDS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .s_color(color_w[0]), .s_valid(valid_w[0]), .s_ready(ready_w[0]),
        .dout(dout_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));
    ws2812_serial_tx #(.T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC), .NUM_LEDS(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .s_color(color_w[1]), .s_valid(valid_w[1]), .s_ready(ready_w[1]),
        .dout(dout_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));
    ws2812_serial_tx #(.T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC), .NUM_LEDS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .s_color(color_w[2]), .s_valid(valid_w[2]), .s_ready(ready_w[2]),
        .dout(dout_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

    function automatic logic [23:0] to_grb(input logic [23:0] c);
        return {c[15:8], c[23:16], c[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int k, input logic [23:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int k, output bit ok, output logic [23:0] v);
        ok = 1'b0;
        v  = '0;
        case (k)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Decodes the line by pulse width; a full 24-bit pixel is checked against the queue.
    task automatic mon(input int k);
        int hcnt = 0;
        int nbits = 0;
        int last_rise = 0;
        logic prev = 1'b0;
        logic d;
        logic b;
        logic [23:0] sh = '0;
        logic [23:0] e;
        bit ok;
        forever begin
            @(negedge clk);
            d = dout_w[k];
            if (!reset_n) begin
                hcnt = 0; nbits = 0; prev = 1'b0;
            end else begin
                if (d) begin
                    if (!prev && nbits > 0) chk($sformatf("bit_period_%0d", k), cyc - last_rise, BITC);
                    if (!prev) last_rise = cyc;
                    hcnt++;
                end else if (prev) begin
                    if (hcnt == T1H) b = 1'b1;
                    else if (hcnt == T0H) b = 1'b0;
                    else begin
                        b = 1'b0;
                        chk($sformatf("pulse_width_%0d", k), hcnt, T0H);
                    end
                    sh = {sh[22:0], b};
                    nbits++;
                    hcnt = 0;
                    if (nbits == 24) begin
                        pop_exp(k, ok, e);
                        chk($sformatf("pixel_expected_%0d", k), 32'(ok), 1);
                        if (ok) chk($sformatf("pixel_bits_%0d", k), 32'(sh), 32'(e));
                        nbits = 0;
                    end
                end
                prev = d;
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    task automatic send(input int k, input logic [23:0] c, input bit push, input bit drop, output int acc);
        int n = 0;
        @(negedge clk);
        color_w[k] = c;
        valid_w[k] = 1'b1;
        while (!ready_w[k] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(ready_w[k]), 1);
        acc = cyc;
        if (push) push_exp(k, to_grb(c));
        @(posedge clk);
        #1;
        if (drop) valid_w[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, output int ic);
        int n = 0;
        @(negedge clk);
        while (busy_w[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        ic = cyc;
        chk("idle_timeout", 32'(busy_w[k]), 0);
    endtask

    task automatic wait_fd(input int k, input int budget, output int fd_cyc, output int hi);
        int n = 0;
        hi = 0;
        fd_cyc = -1;
        while (n < budget) begin
            if (dout_w[k]) hi++;
            if (fd_w[k]) begin
                fd_cyc = cyc;
                break;
            end
            @(negedge clk);
            n++;
        end
        chk("frame_done_timeout", 32'(fd_cyc >= 0), 1);
    endtask

    initial begin
        int acc, fdc, hi, ic, fd_before, rc, rdy_hi, budget;
        int t [3];
        logic [23:0] cols [3];
        t = '{0, 0, 0};
        cols[0] = 24'h010203;
        cols[1] = 24'h040506;
        cols[2] = 24'h070809;
        reset_n = 1'b0;
        valid_w = '0;
        for (int i = 0; i < 3; i++) color_w[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst_dout", 32'(dout_w[k]), 0);
            chk("rst_busy", 32'(busy_w[k]), 0);
            chk("rst_ready", 32'(ready_w[k]), 0);
            chk("rst_frame_done", 32'(fd_w[k]), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("idle_ready", 32'(ready_w[k]), 1);

        // 1) single pixel frame
        send(0, 24'hFF0000, 1'b1, 1'b1, acc);
        @(negedge clk);
        chk("t1_latency", 32'(dout_w[0]), 1);
        chk("t1_busy", 32'(busy_w[0]), 1);
        wait_fd(0, 6000, fdc, hi);
        chk("t1_high_cycles", hi, 8 * T0H + 8 * T1H + 8 * T0H);
        chk("t1_fd_time", fdc - acc, PIXC + RSTC);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy_w[0]), 0);
        chk("t1_ready_after", 32'(ready_w[0]), 1);

        // 2) three back-to-back pixels with valid held, 6) valid toggling in LATCH
        color_w[1] = cols[0];
        valid_w[1] = 1'b1;
        rc = 0; rdy_hi = 0; budget = 0; fdc = -1;
        while (budget < 20000 && fdc < 0) begin
            if (fd_w[1]) fdc = cyc;
            if (ready_w[1]) rdy_hi++;
            if (ready_w[1] && valid_w[1]) begin
                if (rc < 3) t[rc] = cyc;
                push_exp(1, to_grb(color_w[1]));
                rc++;
            end
            @(posedge clk);
            #1;
            if (rc < 3) color_w[1] = cols[rc];
            else if (fdc < 0) valid_w[1] = ~valid_w[1];
            else valid_w[1] = 1'b0;
            if (fdc < 0) @(negedge clk);
            budget++;
        end
        chk("t2_fd_seen", 32'(fdc >= 0), 1);
        chk("t2_transfers", rc, 3);
        chk("t2_ready_cycles", rdy_hi, 3);
        chk("t2_gap_01", t[1] - t[0], PIXC);
        chk("t2_gap_12", t[2] - t[1], PIXC);
        chk("t2_fd_time", fdc - t[2], PIXC + RSTC);
        @(negedge clk);
        chk("t2_ready_idle", 32'(ready_w[1]), 1);
        chk("t2_busy_idle", 32'(busy_w[1]), 0);

        // 3) two pixels with a 1000-cycle gap stay in one frame
        fd_before = fd_cnt[2];
        send(2, 24'hA1B2C3, 1'b1, 1'b1, acc);
        wait_idle(2, 3000, ic);
        chk("t3_idle_time", ic - acc, PIXC + 1);
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            if (dout_w[2] || busy_w[2]) hi++;
            @(negedge clk);
        end
        chk("t3_gap_quiet", hi, 0);
        chk("t3_gap_no_fd", fd_cnt[2] - fd_before, 0);
        send(2, 24'h5D6E7F, 1'b1, 1'b1, acc);
        @(negedge clk);
        wait_fd(2, 6000, fdc, hi);
        chk("t3_fd_time", fdc - acc, PIXC + RSTC);
        @(negedge clk);
        chk("t3_fd_count", fd_cnt[2] - fd_before, 1);

        // 4) starvation latches a partial frame
        fd_before = fd_cnt[2];
        send(2, 24'h123456, 1'b1, 1'b1, acc);
        wait_idle(2, 3000, ic);
        wait_fd(2, 4000, fdc, hi);
        chk("t4_starve_time", fdc - ic, RSTC - 1);
        chk("t4_starve_dout", hi, 0);
        @(negedge clk);
        chk("t4_fd_count", fd_cnt[2] - fd_before, 1);
        send(2, 24'h0F0F0F, 1'b1, 1'b1, acc);
        wait_idle(2, 3000, ic);
        repeat (5) @(negedge clk);
        chk("t4_new_frame_open", 32'(busy_w[2]), 0);
        chk("t4_no_early_latch", fd_cnt[2] - fd_before, 1);
        send(2, 24'hF0F0F0, 1'b1, 1'b1, acc);
        @(negedge clk);
        wait_fd(2, 6000, fdc, hi);
        chk("t4_fd_time", fdc - acc, PIXC + RSTC);

        // 5) reset in the middle of bit 10
        send(0, 24'hFFFFFF, 1'b0, 1'b1, acc);
        repeat (10 * BITC + 5) @(negedge clk);
        chk("t5_pre_dout", 32'(dout_w[0]), 1);
        chk("t5_pre_busy", 32'(busy_w[0]), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t5_rst_dout", 32'(dout_w[0]), 0);
        chk("t5_rst_busy", 32'(busy_w[0]), 0);
        chk("t5_rst_ready", 32'(ready_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("t5_release_ready", 32'(ready_w[0]), 0);
        @(negedge clk);
        chk("t5_ready_after", 32'(ready_w[0]), 1);
        send(0, 24'h5A3C96, 1'b1, 1'b1, acc);
        @(negedge clk);
        wait_fd(0, 6000, fdc, hi);
        chk("t5_fd_time", fdc - acc, PIXC + RSTC);

        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
